alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Alarm controller between the mm:ss time counters and the song player. Holds a user-settable alarm time and compares it against the running time. On a match it asserts `play_sound`, which drives the song player's `playSound` input, until the user stops it, the ring timeout expires, or the alarm is disarmed. It also supports a timed snooze and exports the alarm time to the display mux for set mode.

## Interface
- `RING_TIMEOUT_S`, 30: seconds of continuous ringing before auto-stop (1..63).
- `SNOOZE_S`, 10: seconds spent in snooze before ringing resumes (1..63).
- `DEFAULT_MIN`, 0: reset value of `alm_min` (0..59).
- `DEFAULT_SEC`, 30: reset value of `alm_sec` (0..59).
- `clock`  in  1  system clock; every input is synchronous to it.
- `reset`  in  1  asynchronous, active-low reset.
- `tick_1hz`  in  1  one-cycle strobe, once per second.
- `cur_min`  in  6  current minutes, binary 0..59.
- `cur_sec`  in  6  current seconds, binary 0..59.
- `arm`  in  1  level; 1 enables the alarm.
- `set_mode`  in  1  level; 1 enables editing of the alarm time.
- `btn_min`  in  1  one-cycle pulse (debounced upstream); increments `alm_min` in set mode.
- `btn_sec`  in  1  one-cycle pulse; increments `alm_sec` in set mode.
- `stop`  in  1  one-cycle pulse; ends ringing or snooze.
- `snooze`  in  1  one-cycle pulse; enters snooze from ringing.
- `play_sound`  out  1  registered; 1 while the alarm rings.
- `alm_min`  out  6  alarm minutes, binary.
- `alm_sec`  out  6  alarm seconds, binary.
- `state`  out  2  current FSM state, for LEDs and debug.

## Operation
- States: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
- Match: `match = (cur_min==alm_min) && (cur_sec==alm_sec)`. `match_q` is the registered copy of `match`. A trigger is the rising edge `match && !match_q`.
- Transition priority, evaluated every cycle, highest first:
  1. `arm==0` → IDLE.
  2. `set_mode==1` → ARMED. Ringing is suppressed and triggers are ignored.
  3. `stop` in RINGING or SNOOZE → ARMED.
  4. `snooze` in RINGING → SNOOZE.
  5. The timer reaching its limit on a `tick_1hz`:
     - RINGING after `RING_TIMEOUT_S` ticks → ARMED.
     - SNOOZE after `SNOOZE_S` ticks → RINGING, with the timer cleared.
  6. A trigger in ARMED → RINGING, with the timer cleared.
- IDLE → ARMED when `arm==1`.
- A trigger is consumed whether or not it fires. A stop during the matching second does not re-ring, because no new edge occurs.
- Set mode: `btn_min` and `btn_sec` each increment their field modulo 60 (59 → 0), and work regardless of `arm`. Simultaneous pulses update both fields in the same cycle. Buttons are ignored outside set mode.
- The timer is a 6-bit count of `tick_1hz` pulses. It is cleared on every state entry and holds in IDLE and ARMED.
- `play_sound` is 1 if and only if the state is RINGING.

## Timing
- Reset values:
  - state = IDLE
  - `play_sound` = 0
  - `alm_min` = `DEFAULT_MIN`, `alm_sec` = `DEFAULT_SEC`
  - timer = 0
  - `match_q` = 1, so no trigger fires at reset when the time equals the alarm.
- Trigger to ringing: `cur_*` changes to match at cycle N. The state becomes RINGING at the edge ending cycle N, and `play_sound` is 1 from cycle N+1.
- `stop` or `snooze` pulse at cycle N: `play_sound` is 0 from cycle N+1.
- Timeout: the `RING_TIMEOUT_S`-th tick after entry clears `play_sound` one cycle later.
- Button pulse at cycle N: the new `alm_*` value is visible at cycle N+1.
- Reset mid-ring clears `play_sound` immediately (asynchronously).

## Configuration
- `ALARM_SNOOZE_EN` defined: the SNOOZE state and `snooze` input behave as described above.
- `ALARM_SNOOZE_EN` undefined: the `snooze` input is ignored and the SNOOZE state is unreachable. Only `stop`, the timeout, `arm` and `set_mode` leave RINGING. The `SNOOZE_S` parameter is unused.

## Structure
- Package `alarm_pkg` holds:
  - the state enum
  - `TIME_W`=6
  - `MAX_MINSEC`=59
- Sub-module `tick_timer` is a 6-bit counter with these ports: `clear` (synchronous), count on `tick_1hz`, compare against a limit, and output `done`. It is instantiated once and shared by the RINGING and SNOOZE states.

## Test plan
- Alarm 00:05, `arm`=1. Step `cur_sec` 04 → 05: `play_sound` rises one cycle later and `state`=2.
- Ringing, pulse `stop` while `cur_sec` is still 05: `play_sound`=0 next cycle, stays 0, `state`=1.
- Ringing, no input, 30 `tick_1hz` pulses: `play_sound` falls after the 30th tick, `state`=1.
- `ALARM_SNOOZE_EN`: ringing, pulse `snooze`, then 10 ticks: `play_sound` 0 during snooze, back to 1 after the 10th tick.
- `set_mode`=1, `alm_sec`=59, pulse `btn_sec` and `btn_min` together with `alm_min`=59: both wrap to 00, no ring while time matches.
- Assert `reset`=0 while ringing: `play_sound`=0 and `alm_*`=00:30 immediately. Release with time 00:30: no ring.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
package alarm_pkg;

  localparam int unsigned TIME_W     = 6;
  localparam int unsigned MAX_MINSEC = 59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  // Minute/second increment that wraps 59 -> 0.
  function automatic logic [TIME_W-1:0] inc_mod60(input logic [TIME_W-1:0] v);
    return (v == TIME_W'(MAX_MINSEC)) ? '0 : v + TIME_W'(1);
  endfunction

endpackage

// File: rtl/alarm_ctrl_tick_timer.sv
// Counts 1 Hz ticks since the last clear; done flags the tick that reaches the limit.
module tick_timer
  import alarm_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              tick_1hz,
  input  logic [TIME_W-1:0] limit,
  output logic              done
);

  logic [TIME_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick_1hz) begin
      count <= count + TIME_W'(1);
    end
  end

  // The limit-th tick is the one arriving while count still holds limit-1.
  assign done = tick_1hz && (count == limit - TIME_W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm-time registers, match edge detect and ring/snooze FSM.
// Define ALARM_SNOOZE_EN to enable the snooze input and SNOOZE state.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT_S = 30,
  parameter int unsigned SNOOZE_S       = 10,
  parameter int unsigned DEFAULT_MIN    = 0,
  parameter int unsigned DEFAULT_SEC    = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic [TIME_W-1:0] cur_min,
  input  logic [TIME_W-1:0] cur_sec,
  input  logic              arm,
  input  logic              set_mode,
  input  logic              btn_min,
  input  logic              btn_sec,
  input  logic              stop,
  input  logic              snooze,
  output logic              play_sound,
  output logic [TIME_W-1:0] alm_min,
  output logic [TIME_W-1:0] alm_sec,
  output logic [1:0]        state
);

  state_t            state_q;
  state_t            state_n;
  logic              match;
  logic              match_q;
  logic              trigger;
  logic              counting;
  logic              timer_clear;
  logic              timer_done;
  logic [TIME_W-1:0] limit;

  assign match    = (cur_min == alm_min) && (cur_sec == alm_sec);
  assign trigger  = match && !match_q;
  assign counting = (state_q == RINGING) || (state_q == SNOOZE);
  assign limit    = (state_q == SNOOZE) ? TIME_W'(SNOOZE_S) : TIME_W'(RING_TIMEOUT_S);

  // Every state entry restarts the shared timer.
  assign timer_clear = (state_n != state_q);

  tick_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear),
    .tick_1hz (tick_1hz && counting),
    .limit    (limit),
    .done     (timer_done)
  );

`ifndef ALARM_SNOOZE_EN
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      play_sound <= 1'b0;
      match_q    <= 1'b1;
    end else begin
      state_q    <= state_n;
      play_sound <= (state_n == RINGING);
      match_q    <= match;
    end
  end

  // Next state, highest priority first: arm, set_mode, stop, snooze, timer, trigger.
  always_comb begin
    state_n = state_q;
    if (!arm) begin
      state_n = IDLE;
    end else if (set_mode) begin
      state_n = ARMED;
    end else begin
      case (state_q)
        IDLE:    state_n = ARMED;
        ARMED:   if (trigger) state_n = RINGING;
        RINGING: begin
          if (stop) state_n = ARMED;
`ifdef ALARM_SNOOZE_EN
          else if (snooze) state_n = SNOOZE;
`endif
          else if (timer_done) state_n = ARMED;
        end
        SNOOZE: begin
          if (stop) state_n = ARMED;
          else if (timer_done) state_n = RINGING;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Alarm time edit; independent of arm.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alm_min <= TIME_W'(DEFAULT_MIN);
      alm_sec <= TIME_W'(DEFAULT_SEC);
    end else if (set_mode) begin
      if (btn_min) alm_min <= inc_mod60(alm_min);
      if (btn_sec) alm_sec <= inc_mod60(alm_sec);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: per-cycle behavioural model plus literal checkpoints.
module tb_alarm_ctrl;

  localparam int RING = 30;
  localparam int SNZ  = 10;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       arm = 1'b0;
  logic       set_mode = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_sec = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic       play_sound;
  logic [5:0] alm_min;
  logic [5:0] alm_sec;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Model: 0 idle, 1 armed, 2 ringing, 3 snooze; ticks counted since entering the state.
  int m_state, m_ticks, m_amin, m_asec, m_ns;
  bit m_prev, m_match;

  alarm_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .arm        (arm),
    .set_mode   (set_mode),
    .btn_min    (btn_min),
    .btn_sec    (btn_sec),
    .stop       (stop),
    .snooze     (snooze),
    .play_sound (play_sound),
    .alm_min    (alm_min),
    .alm_sec    (alm_sec),
    .state      (state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_ticks = 0; m_amin = 0; m_asec = 30; m_prev = 1'b1;
    end else begin
      m_match = (int'(cur_min) == m_amin) && (int'(cur_sec) == m_asec);
      m_ns = m_state;
      if (!arm) m_ns = 0;
      else if (set_mode) m_ns = 1;
      else if (m_state == 0) m_ns = 1;
      else if (stop && m_state >= 2) m_ns = 1;
      else if (SNZ_EN && snooze && m_state == 2) m_ns = 3;
      else if (tick_1hz && m_state == 2 && m_ticks + 1 == RING) m_ns = 1;
      else if (tick_1hz && m_state == 3 && m_ticks + 1 == SNZ) m_ns = 2;
      else if (m_state == 1 && m_match && !m_prev) m_ns = 2;
      if (m_ns != m_state) m_ticks = 0;
      else if (tick_1hz && m_state >= 2) m_ticks = m_ticks + 1;
      m_state = m_ns;
      m_prev  = m_match;
      if (set_mode) begin
        if (btn_min) m_amin = (m_amin + 1) % 60;
        if (btn_sec) m_asec = (m_asec + 1) % 60;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cyc_play",  int'(play_sound), int'(m_state == 2));
      chk("cyc_state", int'(state), m_state);
      chk("cyc_amin",  int'(alm_min), m_amin);
      chk("cyc_asec",  int'(alm_sec), m_asec);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
  endtask

  // Force a fresh match edge at 00:05 (alarm expected at 00:05).
  task automatic retrigger();
    cur_sec = 6'd6; step(1); cur_sec = 6'd5; step(1);
  endtask

  initial begin
    step(2);
    cmp_en = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_play", int'(play_sound), 0);
    chk("rst_amin", int'(alm_min), 0);
    chk("rst_asec", int'(alm_sec), 30);
    reset = 1'b1; arm = 1'b1;
    step(1);
    chk("arm_state", int'(state), 1);

    // Program alarm to 00:05 (30 -> 59 -> 00 -> 05 is 35 presses).
    set_mode = 1'b1;
    for (int i = 0; i < 35; i++) begin
      btn_sec = 1'b1; step(1); btn_sec = 1'b0; step(1);
    end
    chk("set_asec5", int'(alm_sec), 5);
    set_mode = 1'b0;
    cur_sec = 6'd4; step(2);
    chk("pre_state", int'(state), 1);
    cur_sec = 6'd5;
    chk("trig_pre", int'(play_sound), 0);
    step(1);
    chk("trig_play", int'(play_sound), 1);
    chk("trig_state", int'(state), 2);

    // Stop during the matching second: no re-ring.
    stop = 1'b1; step(1); stop = 1'b0;
    chk("stop_play", int'(play_sound), 0);
    chk("stop_state", int'(state), 1);
    step(4);
    chk("stop_hold", int'(play_sound), 0);

    // Ring timeout.
    retrigger();
    chk("to_start", int'(play_sound), 1);
    for (int i = 1; i <= RING; i++) begin
      do_tick();
      if (i == RING - 1) chk("to_29", int'(play_sound), 1);
      if (i == RING) begin
        chk("to_30_play", int'(play_sound), 0);
        chk("to_30_state", int'(state), 1);
      end
      step(1);
    end

    // Snooze (or ignored snooze in the default build).
    retrigger();
    snooze = 1'b1; step(1); snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    chk("snz_play", int'(play_sound), 0);
    chk("snz_state", int'(state), 3);
    for (int i = 1; i <= SNZ; i++) begin
      do_tick();
      if (i == SNZ - 1) chk("snz_9", int'(play_sound), 0);
      if (i == SNZ) begin
        chk("snz_10_play", int'(play_sound), 1);
        chk("snz_10_state", int'(state), 2);
      end
      step(1);
    end
`else
    chk("snz_ign_play", int'(play_sound), 1);
    chk("snz_ign_state", int'(state), 2);
`endif
    stop = 1'b1; step(1); stop = 1'b0;
    chk("stop2_state", int'(state), 1);

    // Disarm and set_mode both end ringing.
    retrigger();
    arm = 1'b0; step(1);
    chk("disarm_state", int'(state), 0);
    chk("disarm_play", int'(play_sound), 0);
    arm = 1'b1; step(1);
    chk("rearm_state", int'(state), 1);
    retrigger();
    set_mode = 1'b1; step(1);
    chk("setm_play", int'(play_sound), 0);
    chk("setm_state", int'(state), 1);

    // Wrap 59:59 -> 00:00 with simultaneous buttons; matching time must not ring.
    cur_min = 6'd0; cur_sec = 6'd0;
    for (int i = 0; i < 54; i++) begin
      btn_min = 1'b1; btn_sec = 1'b1; step(1);
      btn_min = 1'b0; btn_sec = 1'b0; step(1);
    end
    for (int i = 0; i < 5; i++) begin
      btn_min = 1'b1; step(1); btn_min = 1'b0; step(1);
    end
    chk("pre_wrap_min", int'(alm_min), 59);
    chk("pre_wrap_sec", int'(alm_sec), 59);
    btn_min = 1'b1; btn_sec = 1'b1; step(1);
    btn_min = 1'b0; btn_sec = 1'b0;
    chk("wrap_min", int'(alm_min), 0);
    chk("wrap_sec", int'(alm_sec), 0);
    step(3);
    chk("wrap_noring", int'(play_sound), 0);
    set_mode = 1'b0; step(3);
    chk("exit_set_state", int'(state), 1);
    chk("exit_set_play", int'(play_sound), 0);
    btn_sec = 1'b1; step(1); btn_sec = 1'b0;
    chk("btn_ignored", int'(alm_sec), 0);

    // Reset mid-ring is immediate; release at matching time does not ring.
    cur_sec = 6'd1; step(1); cur_sec = 6'd0; step(1);
    chk("ring_00", int'(play_sound), 1);
    cur_sec = 6'd30;
    reset = 1'b0;
    #1;
    chk("arst_play", int'(play_sound), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_amin", int'(alm_min), 0);
    chk("arst_asec", int'(alm_sec), 30);
    step(2);
    reset = 1'b1;
    step(3);
    chk("rel_state", int'(state), 1);
    chk("rel_play", int'(play_sound), 0);

    @(negedge clock);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
